bus_tgt408: RTL and testbench



---
 rtl/iop408_bus_pkg.sv | 20 ++
 rtl/bus_tgt408_if.sv | 17 +
 rtl/iop408_sp_ram.sv | 25 ++
 rtl/bus_tgt408.sv | 111 +++++++++++
 tb/tb_bus_tgt408.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/iop408_bus_pkg.sv
// Shared types and helpers for IOP408 bus targets.
package iop408_bus_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } tgt_state_e;

  // True when addr falls in the 2^abits window starting at base.
  function automatic logic win_hit(input logic [ADDR_W-1:0] addr,
                                   input logic [ADDR_W-1:0] base,
                                   input int unsigned       abits);
    return (addr >> abits) == (base >> abits);
  endfunction

endpackage

// File: rtl/bus_tgt408_if.sv
// IOP408 load-store bus: initiator drives request, target drives response.
interface bus_tgt408_if;
  import iop408_bus_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] rdata;
  logic              rdy;
  logic              proto_err;

  modport master (output addr, wdata, read, write,
                  input  rdata, rdy, proto_err);
  modport slave  (input  addr, wdata, read, write,
                  output rdata, rdy, proto_err);
endinterface

// File: rtl/iop408_sp_ram.sv
// Synchronous single-port RAM with registered read, contents not reset.
module iop408_sp_ram
  import iop408_bus_pkg::*;
#(
  parameter int unsigned AW = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     a,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[a] <= d;
    end
    q <= mem_q[a];
  end

endmodule

// File: rtl/bus_tgt408.sv
// IOP408 memory-mapped target: window decode, wait-state insertion,
// one-cycle rdy pulse, rdata zero outside a response for OR-ed buses.
module bus_tgt408
  import iop408_bus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 16'h8000,
  parameter int unsigned       ADDR_BITS   = 10,
  parameter int unsigned       WAIT_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  bus_tgt408_if.slave  bus
);

  tgt_state_e          state_q;
  logic [3:0]          cnt_q;
  logic [ADDR_BITS-1:0] idx_q;
  logic [DATA_W-1:0]   data_q;
  logic                wr_q;
  logic                rdy_q;
  logic                err_q;

  logic                req_c;
  logic                hit_c;
  logic                accept_c;
  logic                wait_go_c;
  logic                ram_we_c;
  logic [ADDR_BITS-1:0] ram_a_c;
  logic [DATA_W-1:0]   ram_d_c;
  logic [DATA_W-1:0]   ram_q;

  assign req_c     = bus.read | bus.write;
  assign hit_c     = win_hit(bus.addr, BASE_ADDR, ADDR_BITS);
  assign accept_c  = (state_q == IDLE) && req_c && hit_c;
  assign wait_go_c = (state_q == WAIT) && req_c && (cnt_q == 4'd1);

  // Zero-wait accesses use the live bus; otherwise the latched copies.
  always_comb begin
    ram_we_c = 1'b0;
    ram_a_c  = idx_q;
    ram_d_c  = data_q;
    if (accept_c && (WAIT_CYCLES == 0)) begin
      ram_we_c = bus.write;
      ram_a_c  = bus.addr[ADDR_BITS-1:0];
      ram_d_c  = bus.wdata;
    end else if (wait_go_c) begin
      ram_we_c = wr_q;
    end
  end

  iop408_sp_ram #(
    .AW (ADDR_BITS)
  ) u_ram (
    .clk (clk),
    .we  (ram_we_c),
    .a   (ram_a_c),
    .d   (ram_d_c),
    .q   (ram_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            idx_q  <= bus.addr[ADDR_BITS-1:0];
            data_q <= bus.wdata;
            wr_q   <= bus.write;
            cnt_q  <= 4'(WAIT_CYCLES);
            if (bus.read && bus.write) begin
              err_q <= 1'b1;
            end
            if (WAIT_CYCLES == 0) begin
              state_q <= RESP;
              rdy_q   <= 1'b1;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!req_c) begin
            state_q <= IDLE;
          end else if (cnt_q == 4'd1) begin
            state_q <= RESP;
            rdy_q   <= 1'b1;
          end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read data is exposed only during the response of a read.
  assign bus.rdata     = (rdy_q && !wr_q) ? ram_q : '0;
  assign bus.rdy       = rdy_q;
  assign bus.proto_err = err_q;

endmodule

// File: tb/tb_bus_tgt408.sv
// Directed bench for bus_tgt408 at wait settings 1, 0 and 3 on one shared driver.
module tb_bus_tgt408;

  logic        clk;
  logic        rst_n;
  logic [15:0] addr_t;
  logic [7:0]  wdata_t;
  logic        rd_t;
  logic        wr_t;
  logic [1:0]  sel;
  logic        rdy_m;
  logic [7:0]  rdata_m;
  logic        err_m;

  int n_tests;
  int n_fail;

  bus_tgt408_if if_w1 ();
  bus_tgt408_if if_w0 ();
  bus_tgt408_if if_w3 ();

  assign if_w1.addr  = addr_t;
  assign if_w1.wdata = wdata_t;
  assign if_w1.read  = rd_t && (sel == 2'd1);
  assign if_w1.write = wr_t && (sel == 2'd1);
  assign if_w0.addr  = addr_t;
  assign if_w0.wdata = wdata_t;
  assign if_w0.read  = rd_t && (sel == 2'd0);
  assign if_w0.write = wr_t && (sel == 2'd0);
  assign if_w3.addr  = addr_t;
  assign if_w3.wdata = wdata_t;
  assign if_w3.read  = rd_t && (sel == 2'd3);
  assign if_w3.write = wr_t && (sel == 2'd3);

  bus_tgt408 #(.BASE_ADDR(16'h8000), .ADDR_BITS(10), .WAIT_CYCLES(1))
    u_w1 (.clk(clk), .rst_n(rst_n), .bus(if_w1));
  bus_tgt408 #(.BASE_ADDR(16'h8000), .ADDR_BITS(10), .WAIT_CYCLES(0))
    u_w0 (.clk(clk), .rst_n(rst_n), .bus(if_w0));
  bus_tgt408 #(.BASE_ADDR(16'h8000), .ADDR_BITS(10), .WAIT_CYCLES(3))
    u_w3 (.clk(clk), .rst_n(rst_n), .bus(if_w3));

  always_comb begin
    rdy_m   = 1'b0;
    rdata_m = 8'h00;
    err_m   = 1'b0;
    case (sel)
      2'd0: begin rdy_m = if_w0.rdy; rdata_m = if_w0.rdata; err_m = if_w0.proto_err; end
      2'd1: begin rdy_m = if_w1.rdy; rdata_m = if_w1.rdata; err_m = if_w1.proto_err; end
      2'd3: begin rdy_m = if_w3.rdy; rdata_m = if_w3.rdata; err_m = if_w3.proto_err; end
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transfer; lat counts edges from first sample to visible rdy.
  task automatic xfer(input logic r, input logic w, input logic [15:0] a,
                      input logic [7:0] d, output int lat, output logic [7:0] q);
    int zero_bad;
    zero_bad = 0;
    lat = -1;
    q = 8'h00;
    addr_t = a; wdata_t = d; rd_t = r; wr_t = w;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (rdy_m) begin
        lat = i;
        q = rdata_m;
        break;
      end else if (rdata_m !== 8'h00) begin
        zero_bad++;
      end
    end
    rd_t = 1'b0; wr_t = 1'b0;
    step();
    check("rdata_while_waiting", 32'(zero_bad), 32'd0);
    check("rdy_after_resp", 32'(rdy_m), 32'd0);
    check("rdata_after_resp", 32'(rdata_m), 32'd0);
  endtask

  task automatic miss(input logic [15:0] a);
    int nr;
    int nd;
    nr = 0; nd = 0;
    addr_t = a; rd_t = 1'b1;
    repeat (20) begin
      step();
      if (rdy_m) nr++;
      if (rdata_m !== 8'h00) nd++;
    end
    rd_t = 1'b0;
    check("miss_rdy", 32'(nr), 32'd0);
    check("miss_rdata", 32'(nd), 32'd0);
  endtask

  initial begin
    int lat;
    logic [7:0] q;
    int nr;
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0; addr_t = 16'h0; wdata_t = 8'h0; rd_t = 1'b0; wr_t = 1'b0; sel = 2'd1;
    repeat (3) step();
    for (int s = 0; s < 4; s++) begin
      if (s != 2) begin
        sel = 2'(s);
        #1;
        check("reset_rdy", 32'(rdy_m), 32'd0);
        check("reset_rdata", 32'(rdata_m), 32'd0);
        check("reset_err", 32'(err_m), 32'd0);
      end
    end
    sel = 2'd1;
    step();
    rst_n = 1'b1;
    step();

    // WAIT_CYCLES=1: write then read back
    xfer(1'b0, 1'b1, 16'h8003, 8'hA5, lat, q);
    check("w1_write_lat", 32'(lat), 32'd2);
    check("w1_write_rdata", 32'(q), 32'd0);
    xfer(1'b1, 1'b0, 16'h8003, 8'h00, lat, q);
    check("w1_read_lat", 32'(lat), 32'd2);
    check("w1_read_data", 32'(q), 32'hA5);

    // Window misses on both sides
    miss(16'h7FFF);
    miss(16'h8400);

    // Read and write together: performed as a write, sticky error
    xfer(1'b1, 1'b1, 16'h8020, 8'hC3, lat, q);
    check("proto_lat", 32'(lat), 32'd2);
    check("proto_err_set", 32'(err_m), 32'd1);
    xfer(1'b1, 1'b0, 16'h8020, 8'h00, lat, q);
    check("proto_readback", 32'(q), 32'hC3);
    check("proto_err_sticky", 32'(err_m), 32'd1);

    // Reset during the wait state of a write
    xfer(1'b0, 1'b1, 16'h8030, 8'h77, lat, q);
    check("rst_pre_write_lat", 32'(lat), 32'd2);
    addr_t = 16'h8030; wdata_t = 8'h99; wr_t = 1'b1;
    step();
    rst_n = 1'b0;
    #1;
    check("rst_async_rdy", 32'(rdy_m), 32'd0);
    check("rst_async_rdata", 32'(rdata_m), 32'd0);
    check("rst_async_err", 32'(err_m), 32'd0);
    wr_t = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    xfer(1'b1, 1'b0, 16'h8030, 8'h00, lat, q);
    check("rst_read_lat", 32'(lat), 32'd2);
    check("rst_ram_kept", 32'(q), 32'h77);
    check("rst_err_clear", 32'(err_m), 32'd0);

    // WAIT_CYCLES=0: back-to-back writes with request held
    sel = 2'd0;
    step();
    for (int i = 0; i < 3; i++) begin
      addr_t = 16'h8000 + 16'(i);
      wdata_t = 8'h11 * 8'(i + 1);
      wr_t = 1'b1;
      step();
      check("b2b_rdy", 32'(rdy_m), 32'd1);
      if (i == 2) wr_t = 1'b0;
      else begin
        addr_t = 16'h8000 + 16'(i + 1);
        wdata_t = 8'h11 * 8'(i + 2);
      end
      step();
      check("b2b_gap", 32'(rdy_m), 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      xfer(1'b1, 1'b0, 16'h8000 + 16'(i), 8'h00, lat, q);
      check("w0_read_lat", 32'(lat), 32'd1);
      check("w0_readback", 32'(q), 32'(8'h11 * 8'(i + 1)));
    end

    // WAIT_CYCLES=3: aborted write leaves the old value
    sel = 2'd3;
    step();
    xfer(1'b0, 1'b1, 16'h8010, 8'h3C, lat, q);
    check("w3_write_lat", 32'(lat), 32'd4);
    addr_t = 16'h8010; wdata_t = 8'h5A; wr_t = 1'b1;
    step();
    step();
    wr_t = 1'b0;
    nr = 0;
    repeat (8) begin
      step();
      if (rdy_m) nr++;
    end
    check("abort_no_rdy", 32'(nr), 32'd0);
    xfer(1'b1, 1'b0, 16'h8010, 8'h00, lat, q);
    check("w3_read_lat", 32'(lat), 32'd4);
    check("abort_old_value", 32'(q), 32'h3C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
